server: RTL
===========

Name: server

Overview:
- Responder end of the client request/size/resp handshake. Accepts a request with a size from an upstream client, waits a programmable delay, and pulses `resp`. It then issues one `beat` per unit of size and pulses `done` in the same cycle the client's own countdown completes.
- Sits downstream of a client's registered `req_out`/`size_out`. Holds one pending request while busy.

Parameters:
- SIZE_W, 3, width of the size field and of `beat_cnt`.
- RESP_DELAY, 2, number of WAIT cycles between request acceptance and `resp`; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  1  request strobe from client; a rising edge (req=1, previous-cycle req=0) is one request
- size  input  SIZE_W  request size; sampled in the rising-edge cycle of `req`
- resp  output  1  one-cycle grant pulse to client
- beat  output  1  high for each serviced unit
- beat_cnt  output  SIZE_W  index of current beat (0..size-1); 0 when `beat`=0
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse when servicing of a request finishes
- overflow  output  1  sticky; a request was dropped

Behaviour:
- Reset values: all outputs 0, state IDLE, pending slot empty, internal `req` history 0. Reset mid-operation aborts everything, with no `done`.
- All outputs are registered/Moore, decoded from state and counters.
- States:
  - IDLE: on `req` edge, latch `size`, load the delay counter with RESP_DELAY, go to WAIT.
  - WAIT: if the delay counter is 0, go to GRANT; else decrement it.
  - GRANT: `resp`=1 for exactly one cycle; load remaining=latched size; go to SERVE.
  - SERVE:
    - If remaining=0: `done`=1 for this cycle, then leave SERVE. Go to WAIT with the pending size if the slot is valid (slot cleared), else go to IDLE.
    - Else: `beat`=1, `beat_cnt`=size-remaining, decrement remaining.
- Timing, with `req` edge in cycle 0 and delay D:
  - WAIT spans cycles 1..D+1.
  - `resp` in cycle D+2.
  - Beats in cycles D+3..D+2+size.
  - `done` in cycle D+3+size.
  - This matches the client: it enters its process state the cycle after `resp` and signals `done` when its count reaches 0.
- size=0: no beats; `done` in the first SERVE cycle (cycle D+3).
- size=2^SIZE_W-1: full range; no wrap of remaining; `beat_cnt` reaches max-1.
- A `req` held high for many cycles counts as one request. A new request requires `req` to drop to 0 for at least one cycle.
- `req` edge while busy:
  - If the pending slot is empty, store `size` in the slot.
  - If the slot is full, drop the request and set `overflow`, which stays set until `rst`.
- Simultaneous `req` edge and `done` cycle:
  - Pending valid: the pending request starts (WAIT), and the new request is written into the now-freed slot. No overflow.
  - Pending empty: the new request goes directly to WAIT with the new size.
- Back-to-back requests through the pending slot have no IDLE gap: `done` is followed immediately by WAIT.
- `busy`=1 in WAIT, GRANT and SERVE, including the `done` cycle.

Decomposition:
- Shared package `server_pkg`:
  - state enum {IDLE, WAIT, GRANT, SERVE}, 2 bits
  - default SIZE_W and RESP_DELAY constants
  - delay-counter width constant (4 bits)
- One sub-module, `server_pending_slot`: a 1-entry buffer with ports clk, rst, wr_en, wr_data[SIZE_W-1:0], rd_en, rd_data, valid and full. A same-cycle rd_en and wr_en results in valid remaining 1, holding the new data.
- Edge detection, the FSM and the counters stay in the top level.

Test Plan:
- Reset mid-SERVE: assert `rst` during a beat -> all outputs 0 in the same cycle (asynchronous); no `done`; `overflow` cleared; next request serviced normally.
- D=2, size=3, `req` edge in cycle 0 -> `resp` in cycle 4; `beat` in cycles 5, 6, 7 with `beat_cnt` 0, 1, 2; `done` in cycle 8; `busy` in cycles 1..8; IDLE in cycle 9.
- size=0, D=0 -> `resp` in cycle 2; no `beat`; `done` in cycle 3.
- `req` held high for 10 cycles with size=2 -> exactly one `resp` and two beats. Drop `req` for 1 cycle and re-raise -> second request queued and serviced after the first.
- Three `req` edges while busy (size 1, 2, 3 after an initial size 4) -> the size-1 request goes to the pending slot; size-2 and size-3 are dropped; `overflow`=1 and stays set. Then a `done` for size 4, WAIT with size 1 in the next cycle, and `done` for size 1 after 1 beat.
- `req` edge (size 5) exactly in a `done` cycle with pending holding size 1 -> size 1 serviced next; size 5 held in the slot and serviced afterwards with 5 beats; `overflow` stays 0.
- Check with a client instance connected to the server (`req_out`/`size_out` → `req`/`size`, `resp` fed back): client and server `done` pulse in the same cycle for sizes 0..7.

Source files
------------

// File: rtl/server_pkg.sv
// server_pkg: shared types and defaults for the server responder.
// State encoding, default sizes and the delay-counter width.
package server_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    GRANT,
    SERVE
  } state_t;

  localparam int SIZE_W_DEF     = 3;
  localparam int RESP_DELAY_DEF = 2;
  localparam int DLY_W          = 4;

endpackage

// File: rtl/server_if.sv
// server_if: client/server request bus.
// master = client side, slave = server side.
interface server_if
  import server_pkg::*;
#(
  parameter int SIZE_W = SIZE_W_DEF
);

  logic              req;
  logic [SIZE_W-1:0] size;
  logic              resp;
  logic              beat;
  logic [SIZE_W-1:0] beat_cnt;
  logic              busy;
  logic              done;
  logic              overflow;

  modport master (
    output req, size,
    input  resp, beat, beat_cnt,
    input  busy, done, overflow
  );

  modport slave (
    input  req, size,
    output resp, beat, beat_cnt,
    output busy, done, overflow
  );

endinterface

// File: rtl/server_pending_slot.sv
// server_pending_slot: one-entry holding buffer.
// A same-cycle read and write keeps it valid with the new data.
module server_pending_slot
  import server_pkg::*;
#(
  parameter int SIZE_W = SIZE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [SIZE_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [SIZE_W-1:0] rd_data,
  output logic              valid,
  output logic              full
);

  logic              r_valid;
  logic [SIZE_W-1:0] r_data;

  // Write wins over read so a swap leaves the slot occupied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (wr_en) begin
      r_valid <= 1'b1;
      r_data  <= wr_data;
    end else if (rd_en) begin
      r_valid <= 1'b0;
    end
  end

  assign rd_data = r_data;
  assign valid   = r_valid;
  assign full    = r_valid;

endmodule

// File: rtl/server.sv
// server: responder for the req/size/resp handshake.
// Delays, grants, beats out the size, then signals done.
module server
  import server_pkg::*;
#(
  parameter int SIZE_W     = SIZE_W_DEF,
  parameter int RESP_DELAY = RESP_DELAY_DEF
) (
  input  logic     clk,
  input  logic     rst,
  server_if.slave  bus
);

  state_t            r_state;
  logic              r_req_d;
  logic [DLY_W-1:0]  r_dly;
  logic [SIZE_W-1:0] r_size;
  logic [SIZE_W-1:0] r_rem;
  logic              r_resp;
  logic              r_beat;
  logic [SIZE_W-1:0] r_beat_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_ovf;

  logic              w_edge;
  logic              w_fin;
  logic              w_act;
  logic              w_wr;
  logic              w_rd;
  logic              w_drop;
  logic              w_valid;
  logic              w_full;
  logic [SIZE_W-1:0] w_rd_data;
  logic [SIZE_W-1:0] w_rem_m1;

  assign w_edge   = bus.req & ~r_req_d;
  assign w_fin    = (r_state == SERVE) && (r_rem == '0);
  assign w_act    = (r_state != IDLE);
  assign w_rem_m1 = r_rem - 1'b1;

  // In the done cycle a waiting entry is consumed, freeing room.
  assign w_wr   = w_edge && w_act && (w_fin ? w_valid : !w_full);
  assign w_rd   = w_fin && w_valid;
  assign w_drop = w_edge && w_act && !w_fin && w_full;

  server_pending_slot #(
    .SIZE_W (SIZE_W)
  ) u_slot (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_wr),
    .wr_data (bus.size),
    .rd_en   (w_rd),
    .rd_data (w_rd_data),
    .valid   (w_valid),
    .full    (w_full)
  );

  // FSM, counters and next-cycle registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_req_d    <= 1'b0;
      r_dly      <= '0;
      r_size     <= '0;
      r_rem      <= '0;
      r_resp     <= 1'b0;
      r_beat     <= 1'b0;
      r_beat_cnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_req_d    <= bus.req;
      r_resp     <= 1'b0;
      r_beat     <= 1'b0;
      r_beat_cnt <= '0;
      r_done     <= 1'b0;
      if (w_drop)
        r_ovf <= 1'b1;
      unique case (r_state)
        IDLE: begin
          if (w_edge) begin
            r_size  <= bus.size;
            r_dly   <= DLY_W'(RESP_DELAY);
            r_state <= WAIT;
            r_busy  <= 1'b1;
          end
        end
        WAIT: begin
          if (r_dly == '0) begin
            r_state <= GRANT;
            r_resp  <= 1'b1;
          end else begin
            r_dly <= r_dly - 1'b1;
          end
        end
        GRANT: begin
          r_rem   <= r_size;
          r_state <= SERVE;
          if (r_size == '0)
            r_done <= 1'b1;
          else
            r_beat <= 1'b1;
        end
        SERVE: begin
          if (w_fin) begin
            if (w_valid) begin
              r_size  <= w_rd_data;
              r_dly   <= DLY_W'(RESP_DELAY);
              r_state <= WAIT;
            end else if (w_edge) begin
              r_size  <= bus.size;
              r_dly   <= DLY_W'(RESP_DELAY);
              r_state <= WAIT;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_rem <= w_rem_m1;
            if (w_rem_m1 == '0) begin
              r_done <= 1'b1;
            end else begin
              r_beat     <= 1'b1;
              r_beat_cnt <= r_size - w_rem_m1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.resp     = r_resp;
  assign bus.beat     = r_beat;
  assign bus.beat_cnt = r_beat_cnt;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.overflow = r_ovf;

endmodule
